// File: rtl/freq_ramp_pkg.sv
// Shared definitions for the frequency ramp sequencer: state encodings,
// frequency width/limit and the setpoint clamp helper.
package freq_ramp_pkg;

  localparam int unsigned FREQ_W = 10;
  localparam logic [FREQ_W-1:0] FREQ_MAX = 10'd1000;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAccel = 3'd1,
    StRun   = 3'd2,
    StDecel = 3'd3,
    StFault = 3'd4
  } ramp_state_e;

  // Setpoints above the legal maximum are pinned to the maximum.
  function automatic logic [FREQ_W-1:0] clamp_setpoint(input logic [FREQ_W-1:0] sp);
    return (sp > FREQ_MAX) ? FREQ_MAX : sp;
  endfunction

endpackage

// File: rtl/ramp_tick.sv
// Free-running ramp tick generator: counts 0..TICK_DIV-1 and pulses tick
// for one cycle when the count sits at TICK_DIV-1.
module ramp_tick #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk_sys,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap the counter at the last count, otherwise increment.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/freq_ramp_ctrl.sv
// Frequency ramp sequencer: ramps freq_out toward the run-gated setpoint at
// STEP_UP / STEP_DN units per ramp tick, handles run/stop and fault, and
// strobes upd whenever freq_out changes.
// Build option: FREQ_RAMP_SOFTSTOP_EN defined -> run=0 decelerates to 0;
// undefined -> run=0 coasts (freq_out forced to 0 immediately).
module freq_ramp_ctrl
  import freq_ramp_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned STEP_UP  = 1,
  parameter int unsigned STEP_DN  = 2
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [9:0]  freq_set,
  input  logic        run,
  input  logic        fault,
  output logic [9:0]  freq_out,
  output logic        upd,
  output logic [2:0]  state,
  output logic        at_speed
);

`ifdef FREQ_RAMP_SOFTSTOP_EN
  localparam bit SoftStop = 1'b1;
`else
  localparam bit SoftStop = 1'b0;
`endif

  localparam logic [FREQ_W:0] StepUpW = (FREQ_W + 1)'(STEP_UP);
  localparam logic [FREQ_W:0] StepDnW = (FREQ_W + 1)'(STEP_DN);

  logic              tick;
  logic [FREQ_W-1:0] tgt;
  logic [FREQ_W:0]   sum;
  logic [FREQ_W:0]   dif;
  logic [FREQ_W-1:0] freq_up, freq_dn;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              upd_q, at_speed_q;
  ramp_state_e       state_q, state_d;

  ramp_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_ramp_tick (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .tick    (tick)
  );

  // Target and the clamped up/down step candidates.
  always_comb begin
    tgt = run ? clamp_setpoint(freq_set) : '0;
    // 11-bit add so the carry past 1023 is visible before clamping to tgt.
    sum     = {1'b0, freq_q} + StepUpW;
    freq_up = (sum > {1'b0, tgt}) ? tgt : sum[FREQ_W-1:0];
    // Borrow check: a step larger than the current value lands on 0.
    dif     = ({1'b0, freq_q} < StepDnW) ? '0 : ({1'b0, freq_q} - StepDnW);
    freq_dn = (dif[FREQ_W-1:0] < tgt) ? tgt : dif[FREQ_W-1:0];
  end

  // Next-state and next-frequency decode; fault overrides everything.
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    if (fault) begin
      state_d = StFault;
      freq_d  = '0;
    end else if (!SoftStop && !run &&
                 (state_q == StAccel || state_q == StRun || state_q == StDecel)) begin
      // Coast stop: drop the output at once.
      state_d = StIdle;
      freq_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          freq_d = '0;
          if (run && tgt != '0) state_d = StAccel;
        end
        StAccel: begin
          // Step only toward the target; reversal is handled by the state change.
          if (tick && freq_q < tgt) freq_d = freq_up;
          if (freq_q == tgt)     state_d = (tgt == '0) ? StIdle : StRun;
          else if (tgt < freq_q) state_d = StDecel;
        end
        StRun: begin
          if (tgt > freq_q)       state_d = StAccel;
          else if (tgt < freq_q)  state_d = StDecel;
          else if (tgt == '0)     state_d = StIdle;
        end
        StDecel: begin
          if (tick && freq_q > tgt) freq_d = freq_dn;
          if (freq_q == tgt)     state_d = (tgt == '0) ? StIdle : StRun;
          else if (tgt > freq_q) state_d = StAccel;
        end
        StFault: begin
          freq_d = '0;
          if (!run) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          freq_d  = '0;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      freq_q     <= '0;
      upd_q      <= 1'b0;
      at_speed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      upd_q      <= (freq_d != freq_q);
      at_speed_q <= (state_d == StRun);
    end
  end

  assign freq_out = freq_q;
  assign upd      = upd_q;
  assign state    = state_q;
  assign at_speed = at_speed_q;

endmodule

// File: tb/tb_freq_ramp_ctrl.sv
// Directed bench for freq_ramp_ctrl with TICK_DIV=4, STEP_UP=1, STEP_DN=2.
module tb_freq_ramp_ctrl;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] freq_set = '0;
  logic       run   = 1'b0;
  logic       fault = 1'b0;
  logic [9:0] freq_out;
  logic       upd;
  logic [2:0] state;
  logic       at_speed;

  int vectors = 0;
  int miscompares = 0;

  freq_ramp_ctrl #(
    .TICK_DIV (4),
    .STEP_UP  (1),
    .STEP_DN  (2)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .freq_set (freq_set),
    .run      (run),
    .fault    (fault),
    .freq_out (freq_out),
    .upd      (upd),
    .state    (state),
    .at_speed (at_speed)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Advance to the next negedge with upd high, within max_cyc cycles.
  task automatic wait_upd(input int max_cyc, output bit got);
    int i;
    got = 1'b0;
    i = 0;
    while (!got && i < max_cyc) begin
      @(negedge clk_sys);
      i++;
      if (upd === 1'b1) got = 1'b1;
    end
  endtask

  task automatic count_upd(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk_sys);
      if (upd === 1'b1) c++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(2);
    vectors++;
    if (freq_out !== 10'd0 || upd !== 1'b0 || state !== 3'd0 || at_speed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got freq=%0d upd=%b st=%0d as=%b, want 0 0 0 0",
               freq_out, upd, state, at_speed);
    end
    rst_n = 1'b1;
    wait_cycles(3);
    vectors++;
    if (freq_out !== 10'd0 || upd !== 1'b0 || state !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release: got freq=%0d upd=%b st=%0d, want 0 0 0",
               freq_out, upd, state);
    end
  endtask

  task automatic test_accel();
    bit got;
    int c;
    freq_set = 10'd5;
    run = 1'b1;
    @(negedge clk_sys);
    vectors++;
    if (state !== 3'd1) begin
      miscompares++;
      $display("FAIL accel_enter: got st=%0d, want 1", state);
    end
    for (int k = 1; k <= 5; k++) begin
      wait_upd(8, got);
      vectors++;
      if (!got || freq_out !== 10'(k)) begin
        miscompares++;
        $display("FAIL accel_step: got upd_seen=%b freq=%0d, want 1 %0d", got, freq_out, k);
      end
    end
    @(negedge clk_sys);
    vectors++;
    if (upd !== 1'b0) begin
      miscompares++;
      $display("FAIL accel_upd_width: got upd=%b, want 0", upd);
    end
    wait_cycles(1);
    vectors++;
    if (state !== 3'd2 || at_speed !== 1'b1 || freq_out !== 10'd5) begin
      miscompares++;
      $display("FAIL accel_run: got st=%0d as=%b freq=%0d, want 2 1 5", state, at_speed, freq_out);
    end
    count_upd(12, c);
    vectors++;
    if (c !== 0) begin
      miscompares++;
      $display("FAIL accel_hold: got %0d upd pulses, want 0", c);
    end
  endtask

  task automatic test_decel();
    bit got;
    int c;
    freq_set = 10'd2;
    @(negedge clk_sys);
    vectors++;
    if (state !== 3'd3 || at_speed !== 1'b0) begin
      miscompares++;
      $display("FAIL decel_enter: got st=%0d as=%b, want 3 0", state, at_speed);
    end
    wait_upd(8, got);
    vectors++;
    if (!got || freq_out !== 10'd3) begin
      miscompares++;
      $display("FAIL decel_step1: got upd_seen=%b freq=%0d, want 1 3", got, freq_out);
    end
    wait_upd(8, got);
    vectors++;
    if (!got || freq_out !== 10'd2) begin
      miscompares++;
      $display("FAIL decel_clamp: got upd_seen=%b freq=%0d, want 1 2", got, freq_out);
    end
    wait_cycles(2);
    vectors++;
    if (state !== 3'd2 || at_speed !== 1'b1) begin
      miscompares++;
      $display("FAIL decel_run: got st=%0d as=%b, want 2 1", state, at_speed);
    end
    count_upd(12, c);
    vectors++;
    if (c !== 0 || freq_out !== 10'd2) begin
      miscompares++;
      $display("FAIL decel_hold: got pulses=%0d freq=%0d, want 0 2", c, freq_out);
    end
  endtask

  task automatic test_stop();
    bit got;
    freq_set = 10'd5;
    for (int k = 3; k <= 5; k++) begin
      wait_upd(10, got);
      vectors++;
      if (!got || freq_out !== 10'(k)) begin
        miscompares++;
        $display("FAIL stop_reramp: got upd_seen=%b freq=%0d, want 1 %0d", got, freq_out, k);
      end
    end
    wait_cycles(2);
    vectors++;
    if (state !== 3'd2) begin
      miscompares++;
      $display("FAIL stop_run: got st=%0d, want 2", state);
    end
    run = 1'b0;
`ifdef FREQ_RAMP_SOFTSTOP_EN
    for (int k = 0; k < 3; k++) begin
      int exp_f;
      exp_f = 3 - 2 * k;
      if (exp_f < 0) exp_f = 0;
      wait_upd(10, got);
      vectors++;
      if (!got || freq_out !== 10'(exp_f)) begin
        miscompares++;
        $display("FAIL stop_soft: got upd_seen=%b freq=%0d, want 1 %0d", got, freq_out, exp_f);
      end
    end
    wait_cycles(2);
    vectors++;
    if (state !== 3'd0 || freq_out !== 10'd0) begin
      miscompares++;
      $display("FAIL stop_idle: got st=%0d freq=%0d, want 0 0", state, freq_out);
    end
`else
    @(negedge clk_sys);
    vectors++;
    if (freq_out !== 10'd0 || upd !== 1'b1 || state !== 3'd0 || at_speed !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_coast: got freq=%0d upd=%b st=%0d as=%b, want 0 1 0 0",
               freq_out, upd, state, at_speed);
    end
`endif
  endtask

  task automatic test_fault();
    bit got;
    freq_set = 10'd10;
    run = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_upd(10, got);
      vectors++;
      if (!got || freq_out !== 10'(k)) begin
        miscompares++;
        $display("FAIL fault_ramp: got upd_seen=%b freq=%0d, want 1 %0d", got, freq_out, k);
      end
    end
    fault = 1'b1;
    @(negedge clk_sys);
    vectors++;
    if (freq_out !== 10'd0 || state !== 3'd4 || upd !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_entry: got freq=%0d st=%0d upd=%b, want 0 4 1", freq_out, state, upd);
    end
    @(negedge clk_sys);
    vectors++;
    if (upd !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_upd_once: got upd=%b, want 0", upd);
    end
    fault = 1'b0;
    wait_cycles(6);
    vectors++;
    if (state !== 3'd4 || freq_out !== 10'd0) begin
      miscompares++;
      $display("FAIL fault_sticky: got st=%0d freq=%0d, want 4 0", state, freq_out);
    end
    run = 1'b0;
    @(negedge clk_sys);
    vectors++;
    if (state !== 3'd0) begin
      miscompares++;
      $display("FAIL fault_exit: got st=%0d, want 0", state);
    end
  endtask

  task automatic test_reset_mid_ramp();
    bit got;
    freq_set = 10'd10;
    run = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_upd(10, got);
      vectors++;
      if (!got || freq_out !== 10'(k)) begin
        miscompares++;
        $display("FAIL rst_ramp: got upd_seen=%b freq=%0d, want 1 %0d", got, freq_out, k);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (freq_out !== 10'd0 || state !== 3'd0 || upd !== 1'b0 || at_speed !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got freq=%0d st=%0d upd=%b as=%b, want 0 0 0 0",
               freq_out, state, upd, at_speed);
    end
    wait_cycles(3);
    rst_n = 1'b1;
    wait_upd(12, got);
    vectors++;
    if (!got || freq_out !== 10'd1) begin
      miscompares++;
      $display("FAIL rst_restart: got upd_seen=%b freq=%0d, want 1 1", got, freq_out);
    end
    run = 1'b0;
    wait_cycles(12);
    vectors++;
    if (state !== 3'd0 || freq_out !== 10'd0) begin
      miscompares++;
      $display("FAIL rst_stop: got st=%0d freq=%0d, want 0 0", state, freq_out);
    end
  endtask

  task automatic test_clamp();
    bit got, ovr, stepbad;
    int c, prev, ups;
    got = 1'b0; ovr = 1'b0; stepbad = 1'b0;
    c = 0; prev = 0; ups = 0;
    freq_set = 10'h3FF;
    run = 1'b1;
    while (!got && c < 4300) begin
      @(negedge clk_sys);
      c++;
      if (upd === 1'b1) begin
        ups++;
        if (int'(freq_out) != prev + 1) stepbad = 1'b1;
        prev = int'(freq_out);
      end
      if (freq_out > 10'd1000) ovr = 1'b1;
      if (state === 3'd2) got = 1'b1;
    end
    vectors++;
    if (!got || freq_out !== 10'd1000 || at_speed !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp_final: got run_seen=%b freq=%0d as=%b, want 1 1000 1",
               got, freq_out, at_speed);
    end
    vectors++;
    if (ups !== 1000 || stepbad || ovr) begin
      miscompares++;
      $display("FAIL clamp_path: got pulses=%0d stepbad=%b over=%b, want 1000 0 0",
               ups, stepbad, ovr);
    end
    count_upd(20, c);
    vectors++;
    if (c !== 0 || freq_out !== 10'd1000) begin
      miscompares++;
      $display("FAIL clamp_hold: got pulses=%0d freq=%0d, want 0 1000", c, freq_out);
    end
    run = 1'b0;
    got = 1'b0;
    c = 0;
    while (!got && c < 2300) begin
      @(negedge clk_sys);
      c++;
      if (state === 3'd0) got = 1'b1;
    end
    vectors++;
    if (!got || freq_out !== 10'd0) begin
      miscompares++;
      $display("FAIL clamp_stop: got idle_seen=%b freq=%0d, want 1 0", got, freq_out);
    end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_decel();
    test_stop();
    test_fault();
    test_reset_mid_ramp();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
